uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side sequencer for the UART RX path. It drives `edge_bit_counter`'s enable and decodes its `edge_cnt`/`bit_cnt` to walk the frame states. It majority-samples `RX_IN` mid-bit, deserializes LSB-first, and checks parity and the stop bit. It sits between the RX pin synchronizer and the byte consumer, and presents `P_DATA` with a one-cycle `data_valid`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, range 5..8.
- `CLK`, input, 1: system clock, oversampled at Prescale × baud.
- `RST`, input, 1: reset, synchronous, active-high.
- `RX_IN`, input, 1: serial line, already synchronized, idle high.
- `PAR_EN`, input, 1: parity bit present.
- `PAR_TYP`, input, 1: 0 = even, 1 = odd.
- `Prescale`, input, 6: oversampling ratio; legal values 8, 16, 32.
- `edge_cnt`, input, 6: from `edge_bit_counter`.
- `bit_cnt`, input, 4: from `edge_bit_counter`.
- `cnt_enable`, output, 1: enable to `edge_bit_counter`.
- `P_DATA`, output, DATA_WIDTH: last good frame's data.
- `data_valid`, output, 1: one-cycle pulse when `P_DATA` updates.
- `par_err`, output, 1: one-cycle pulse, parity mismatch.
- `stp_err`, output, 1: one-cycle pulse, stop bit sampled low.
- `strt_glitch`, output, 1: one-cycle pulse, start bit sampled high.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Counter contract:
  - Counter is cleared while `cnt_enable` is 0.
  - `edge_cnt` runs 0..Prescale-1, then wraps to 0 and increments `bit_cnt`.
  - In bit 0 the counter goes 0→3. All sample edges are ≥3 for Prescale ≥ 8, so this does not affect sampling.
- `Prescale` is latched into `presc_q` on the IDLE→START transition. All decode uses `presc_q`.
- Decode points, with mid = presc_q>>1:
  - Sample edges: mid-1, mid, mid+1. `RX_IN` is captured at each.
  - Vote edge: mid+2. The sampled bit is the majority of the 3 captures, valid on this edge.
  - End edge: presc_q-1.
- States (encoded per the package constants):
  - IDLE: `cnt_enable`=0. `RX_IN`==0 → START.
  - START (`bit_cnt` 0): vote=1 → pulse `strt_glitch`, go to IDLE. End edge → DATA.
  - DATA (`bit_cnt` 1..DATA_WIDTH):
    - Vote edge: shift the sampled bit into the MSB of `shreg`, so the first received bit ends in bit 0.
    - Vote edge: fold the bit into the running XOR.
    - End edge with `bit_cnt`==DATA_WIDTH → PARITY if `PAR_EN`, else STOP.
  - PARITY:
    - Vote edge: `par_fail` = (XOR of data ^ `PAR_TYP`) != sampled bit.
    - End edge → STOP.
  - STOP, at the vote edge:
    - Sampled bit 0 → pulse `stp_err`.
    - Else if `par_fail` → pulse `par_err`.
    - Else load `P_DATA` from `shreg` and pulse `data_valid`.
    - In all three cases, go to IDLE in the same cycle.
- Exiting at the stop-bit vote edge leaves about half a bit for resync, so back-to-back frames work with no idle gap.
- `PAR_EN`, `PAR_TYP` and `DATA_WIDTH`-relevant inputs must be stable while `busy`. They are sampled live; changing them mid-frame is undefined.
- Illegal `Prescale` values are undefined.

## Timing
- Reset values: `cnt_enable` 0, `P_DATA` 0, all pulses 0, `busy` 0, state IDLE. Internal `shreg`, `par_fail` and `presc_q` are also cleared.
- `RST` mid-frame returns the block to IDLE on the next edge with no output pulse. The counter clears on the following cycle because `cnt_enable` is 0.
- `cnt_enable` is registered and rises the cycle after `RX_IN` is first seen low.
- Result latency: `data_valid`, `par_err` and `stp_err` assert one cycle after the stop-bit vote edge.
- Output pulses:
  - At most one of `data_valid`, `par_err`, `stp_err`, `strt_glitch` asserts per frame.
  - Each pulse lasts exactly 1 cycle.
- `P_DATA` holds until the next `data_valid`. It is unchanged on error frames.
- `RX_IN` low in IDLE on the same cycle as the exit from STOP is seen on the next cycle. This costs no more than 1 edge of skew.

## Structure
- Package `uart_rx_pkg` holds:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Localparam for the vote offset (+2).
  - Legal Prescale constants.
- Natural sub-module: `data_sampler`. It takes the 3-edge capture and majority vote, with inputs `edge_cnt`, `presc_q`, `RX_IN`. It outputs `samp_bit` and `samp_vld`, where `samp_vld` pulses on the vote edge.
- The FSM, shift register and parity check stay in `uart_rx_ctrl`. `edge_bit_counter` is instantiated alongside it at the top level, not inside this block.

## Test plan
- Prescale=8, PAR_EN=0, byte 0xA5, clean line → `P_DATA`=0xA5 and a 1-cycle `data_valid`; `busy` falls at the stop-bit vote edge.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with correct parity 0 → `data_valid` with 0x3C. Same frame with parity bit 1 → `par_err` pulse and `P_DATA` keeps its old value.
- Prescale=32, 2-edge low glitch on `RX_IN` in IDLE → `strt_glitch` pulse, return to IDLE, no other pulse.
- Prescale=8, stop bit driven 0 → `stp_err` pulse. A subsequent valid frame 0x5A starting immediately is received correctly.
- Prescale=16, `RST` held 1 cycle during DATA bit 4 → IDLE next cycle, `cnt_enable`=0, no pulses. The next frame 0xFF is received correctly.
- Prescale=8, one sample per bit inverted at edge mid-1 → all frames received correctly via majority vote.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer and its sampler.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   localparam logic [5:0] LP_VOTE_OFS = 6'd2;

   localparam logic [5:0] LP_PRESC_8  = 6'd8;
   localparam logic [5:0] LP_PRESC_16 = 6'd16;
   localparam logic [5:0] LP_PRESC_32 = 6'd32;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic presc_legal(input logic [5:0] p);
      return (p == LP_PRESC_8) || (p == LP_PRESC_16) || (p == LP_PRESC_32);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_data_sampler.sv
// Captures the line on the three edges around mid-bit and presents the
// majority vote, qualified on the edge two past mid.
module data_sampler
   import uart_rx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_edge_cnt,
   input  logic [5:0] i_presc_q,
   input  logic       i_rx_in,
   output logic       o_samp_bit,
   output logic       o_samp_vld
);

   logic [5:0] w_mid;
   logic [2:0] r_samp;

   assign w_mid = i_presc_q >> 1'b1;

   // capture RX_IN at mid-1, mid and mid+1
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_samp <= 3'b000;
      end else if (i_edge_cnt == (w_mid - 6'd1)) begin
         r_samp[0] <= i_rx_in;
      end else if (i_edge_cnt == w_mid) begin
         r_samp[1] <= i_rx_in;
      end else if (i_edge_cnt == (w_mid + 6'd1)) begin
         r_samp[2] <= i_rx_in;
      end else begin
         r_samp <= r_samp;
      end
   end

   assign o_samp_vld = (i_edge_cnt == (w_mid + LP_VOTE_OFS));
   assign o_samp_bit = majority3(r_samp[0], r_samp[1], r_samp[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks start/data/parity/stop using the external
// edge/bit counter, deserializes LSB-first and reports one result per frame.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   input  logic [5:0]            edge_cnt,
   input  logic [3:0]            bit_cnt,
   output logic                  cnt_enable,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  strt_glitch,
   output logic                  busy
);

   localparam logic [3:0] LP_LAST_BIT = 4'(DATA_WIDTH);

   rx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_shreg;
   logic                  r_xor;
   logic                  r_par_fail;
   logic [5:0]            r_presc_q;
   logic                  w_samp_bit;
   logic                  w_samp_vld;
   logic                  w_end_edge;

   data_sampler u_data_sampler (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_edge_cnt (edge_cnt),
      .i_presc_q  (r_presc_q),
      .i_rx_in    (RX_IN),
      .o_samp_bit (w_samp_bit),
      .o_samp_vld (w_samp_vld)
   );

   assign w_end_edge = (edge_cnt == (r_presc_q - 6'd1));

   // frame FSM with registered enable, busy, data and result pulses
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_xor       <= 1'b0;
         r_par_fail  <= 1'b0;
         r_presc_q   <= 6'd0;
         cnt_enable  <= 1'b0;
         busy        <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!RX_IN) begin
                  r_state    <= ST_START;
                  cnt_enable <= 1'b1;
                  busy       <= 1'b1;
                  r_xor      <= 1'b0;
                  r_par_fail <= 1'b0;
                  // an out-of-range ratio falls back to 16 rather than a broken decode
                  r_presc_q  <= presc_legal(Prescale) ? Prescale : LP_PRESC_16;
               end else begin
                  cnt_enable <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            ST_START: begin
               if (w_samp_vld && w_samp_bit) begin
                  strt_glitch <= 1'b1;
                  r_state     <= ST_IDLE;
                  cnt_enable  <= 1'b0;
                  busy        <= 1'b0;
               end else if (w_end_edge) begin
                  r_state <= ST_DATA;
               end else begin
                  r_state <= ST_START;
               end
            end
            ST_DATA: begin
               if (w_samp_vld) begin
                  r_shreg <= {w_samp_bit, r_shreg[DATA_WIDTH-1:1]};
                  r_xor   <= r_xor ^ w_samp_bit;
               end else begin
                  r_shreg <= r_shreg;
               end
               if (w_end_edge && (bit_cnt == LP_LAST_BIT)) begin
                  r_state <= PAR_EN ? ST_PARITY : ST_STOP;
               end else begin
                  r_state <= ST_DATA;
               end
            end
            ST_PARITY: begin
               if (w_samp_vld) begin
                  r_par_fail <= ((r_xor ^ PAR_TYP) != w_samp_bit);
               end else begin
                  r_par_fail <= r_par_fail;
               end
               r_state <= w_end_edge ? ST_STOP : ST_PARITY;
            end
            ST_STOP: begin
               // leave at the vote edge so the next start bit can be caught with no gap
               if (w_samp_vld) begin
                  if (!w_samp_bit) begin
                     stp_err <= 1'b1;
                  end else if (r_par_fail) begin
                     par_err <= 1'b1;
                  end else begin
                     P_DATA     <= r_shreg;
                     data_valid <= 1'b1;
                  end
                  r_state    <= ST_IDLE;
                  cnt_enable <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  r_state <= ST_STOP;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               cnt_enable <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural edge/bit counter.
module tb_uart_rx_ctrl;

   localparam logic [3:0] K_DV = 4'b1000;
   localparam logic [3:0] K_PE = 4'b0100;
   localparam logic [3:0] K_SE = 4'b0010;
   localparam logic [3:0] K_SG = 4'b0001;

   typedef struct {
      logic [3:0] code;
      logic [7:0] data;
   } exp_t;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       cnt_enable;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;
   logic       busy;

   exp_t sb_q[$];
   int   n_vec;
   int   n_err;

   uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .Prescale    (Prescale),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .cnt_enable  (cnt_enable),
      .P_DATA      (P_DATA),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .strt_glitch (strt_glitch),
      .busy        (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // edge_bit_counter stand-in
   always @(posedge CLK) begin
      if (RST || !cnt_enable) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= 4'd0;
      end else if (edge_cnt == (Prescale - 6'd1)) begin
         edge_cnt <= 6'd0;
         bit_cnt  <= bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + 6'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_ev(input logic [3:0] code, input logic [7:0] data);
      exp_t e;
      e.code = code;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1 RX_IN = 1'b1;
      end
   endtask

   // rst_at: line bit index at which RST is pulsed and the frame abandoned (-1 = never)
   task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                             input bit pbit, input bit stopv, input bit inv, input int rst_at);
      logic line [0:10];
      int   n;
      n = pen ? 11 : 10;
      line[0] = 1'b0;
      for (int i = 0; i < 8; i++) line[i+1] = d[i];
      if (pen) line[9] = pbit;
      line[n-1] = stopv;
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < p; c++) begin
            @(posedge CLK);
            #1;
            if (b == rst_at && c == 0) begin
               RST   = 1'b1;
               RX_IN = 1'b1;
               @(posedge CLK);
               #1 RST = 1'b0;
               return;
            end
            RX_IN = (inv && c == (p / 2)) ? ~line[b] : line[b];
            if (b == 0 && c < 2) begin
               @(negedge CLK);
               chk(c == 0 ? "cnt_en_before_start" : "cnt_en_after_start",
                   {31'd0, cnt_enable}, (c == 0) ? 32'd0 : 32'd1);
            end
         end
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      RST      = 1'b1;
      RX_IN    = 1'b1;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      Prescale = 6'd8;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cnt_enable", {31'd0, cnt_enable}, 32'd0);
      chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
      chk("rst_pulses", {28'd0, data_valid, par_err, stp_err, strt_glitch}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge CLK);
      #1 RST = 1'b0;

      // monitor: every result pulse must match the head of the scoreboard
      fork
         forever begin
            @(negedge CLK);
            if (data_valid | par_err | stp_err | strt_glitch) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_pulse", {28'd0, data_valid, par_err, stp_err, strt_glitch}, 32'd0);
               end else begin
                  exp_t e;
                  e = sb_q.pop_front();
                  chk("pulse_kind", {28'd0, data_valid, par_err, stp_err, strt_glitch}, {28'd0, e.code});
                  chk("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                  chk("busy_at_result", {31'd0, busy}, 32'd0);
                  chk("cnt_en_at_result", {31'd0, cnt_enable}, 32'd0);
               end
            end
         end
      join_none

      idle(5);
      // Prescale 8, no parity, 0xA5
      expect_ev(K_DV, 8'hA5);
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idle(4);
      // Prescale 16, even parity, 0x3C good then bad parity bit
      expect_ev(K_DV, 8'h3C);
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      expect_ev(K_PE, 8'h3C);
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      idle(4);
      // odd parity: 0x07 has three ones, parity bit 0
      expect_ev(K_DV, 8'h07);
      send_frame(8'h07, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
      idle(4);
      // Prescale 32, two-cycle low glitch in IDLE
      Prescale = 6'd32;
      PAR_EN   = 1'b0;
      expect_ev(K_SG, 8'h07);
      repeat (2) begin
         @(posedge CLK);
         #1 RX_IN = 1'b0;
      end
      idle(60);
      // Prescale 8, bad stop bit, then 0x5A back to back
      expect_ev(K_SE, 8'h07);
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      expect_ev(K_DV, 8'h5A);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idle(4);
      // Prescale 16, reset during data bit 4, then 0xFF
      send_frame(8'h77, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
      @(negedge CLK);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_cnt_en", {31'd0, cnt_enable}, 32'd0);
      chk("mid_rst_p_data", {24'd0, P_DATA}, 32'd0);
      idle(20);
      expect_ev(K_DV, 8'hFF);
      send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idle(4);
      // Prescale 8, one sample per bit inverted at mid-1
      expect_ev(K_DV, 8'hC3);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      expect_ev(K_DV, 8'h96);
      send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      expect_ev(K_DV, 8'h2B);
      send_frame(8'h2B, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      idle(40);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
